estendedor_pulso: RTL
=====================

ESTENDEDOR_PULSO -- requirements
Module: estendedor_pulso

Interface
REQ-001 SHALL have parameter N_CANAIS, default 2, number of independent channels.
REQ-002 SHALL have parameter LARGURA, default 4, output pulse width in clk cycles; legal range 1..255.
REQ-003 SHALL have parameter ESPERA, default 2, hold-off cycles after each pulse; legal range 0..255.
REQ-004 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit, reset, asynchronous, active-high.
REQ-006 SHALL have port entrada, input, N_CANAIS bits, per-channel trigger, sampled at each rising clk edge.
REQ-007 SHALL have port modo, input, 1 bit, retrigger select: 0 = ignore triggers while high, 1 = restart width; shared by all channels.
REQ-008 SHALL have port saida, output, N_CANAIS bits, per-channel stretched pulse.
REQ-009 SHALL have port ocupado, output, N_CANAIS bits, per-channel "not idle" flag.
REQ-010 SHALL have port fim, output, N_CANAIS bits, one-cycle end-of-pulse strobe.

Function
REQ-011 SHALL drive all outputs from registers; no combinational path from any input to any output.
REQ-012 SHALL run each channel independently, each with FSM states OCIOSO, ALTO, ESPERA and its own down-counter.
REQ-013 In OCIOSO with entrada[i]=1 at an edge, the channel SHALL go to ALTO, load the counter with LARGURA-1 and set saida[i]=1 at that edge.
REQ-014 In ALTO with counter>0, each edge SHALL decrement the counter, keeping saida[i]=1.
REQ-015 In ALTO with counter=0 and no accepted retrigger, the edge SHALL clear saida[i], pulse fim[i]=1 for exactly one cycle and go to ESPERA.
REQ-016 On entering ESPERA, the counter SHALL load ESPERA-1; if ESPERA=0, the channel SHALL go directly to OCIOSO.
REQ-017 ESPERA SHALL last ESPERA cycles, then go to OCIOSO.
REQ-018 Triggers in ESPERA, and on the edge that leaves ALTO or ESPERA, SHALL be ignored.
REQ-019 saida SHALL therefore be high exactly LARGURA cycles per accepted trigger, with a minimum low gap of ESPERA+1 cycles.
REQ-020 In ALTO with modo=1 and entrada[i]=1, the counter SHALL reload to LARGURA-1, including at counter=0; retrigger takes priority over termination and no fim is emitted.
REQ-021 With modo=0, triggers in ALTO SHALL have no effect.
REQ-022 entrada is level-sampled: a trigger held high SHALL repeat pulses at period LARGURA+ESPERA+1 (modo=0).
REQ-023 ocupado[i] SHALL be 1 whenever the channel state is not OCIOSO.
REQ-024 The counter width SHALL be 8 bits, and SHALL not wrap below 0.

Reset
REQ-025 rst=1 SHALL immediately force all channels to OCIOSO, counters 0, and saida, ocupado, fim to 0, including mid-pulse.
REQ-026 After rst deasserts, the first trigger SHALL be accepted at the first rising edge with entrada=1.
REQ-027 No fim SHALL be emitted for a pulse aborted by reset.

Structure
REQ-028 State encoding (OCIOSO, ALTO, ESPERA) and the counter width constant SHALL live in a shared package.
REQ-029 The per-channel FSM and counter SHALL be a sub-module estendedor_canal, instantiated N_CANAIS times by a generate loop.

Verification (LARGURA=4, ESPERA=2; edge k = trigger edge)
REQ-030 Single trigger, modo=0: entrada=01 for one cycle at edge k -> saida[0]=1 after edges k..k+3; fim[0]=1 after edge k+4 only; ocupado[0] falls after edge k+6; saida[1] stays 0.
REQ-031 Retrigger, modo=1: entrada[0] pulses at k and k+2 -> saida[0] high after edges k..k+5; single fim after edge k+6.
REQ-032 Ignored retrigger, modo=0: same stimulus as REQ-031 -> behaviour identical to REQ-030.
REQ-033 Held trigger: entrada=11 held constant -> both channels produce 4-high/3-low periodic pulses in lockstep, one fim per pulse.
REQ-034 Hold-off: trigger at k+5, during ESPERA -> ignored; trigger at k+7 -> accepted, saida[0]=1 after edge k+7.
REQ-035 Reset mid-pulse: rst asserted between edges k+1 and k+2 -> saida, ocupado, fim are 0 immediately and no fim follows; a trigger after release starts a full 4-cycle pulse.

Source files
------------

// File: rtl/estendedor_pulso_pkg.sv
// Shared definitions for the pulse stretcher: channel state encoding,
// counter width and the helper that turns a cycle count into a counter load.
package estendedor_pulso_pkg;

    localparam int LARGURA_CONT = 8;

    typedef logic [LARGURA_CONT-1:0] contador_t;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ALTO   = 2'd1,
        ESPERA = 2'd2
    } estado_t;

    // A phase of N cycles counts N-1 down to 0; a zero-length phase loads 0
    // instead of wrapping to all-ones.
    function automatic contador_t carga(input int unsigned ciclos);
        if (ciclos == 0) begin
            return '0;
        end
        return contador_t'(ciclos - 1);
    endfunction

endpackage

// File: rtl/estendedor_canal.sv
// One pulse-stretcher channel: OCIOSO/ALTO/ESPERA state machine plus an
// 8-bit down-counter. All outputs are decoded from registered state.
module estendedor_canal
    import estendedor_pulso_pkg::*;
#(
    parameter int LARGURA  = 4,
    parameter int N_ESPERA = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    entrada,
    input  logic    modo,
    output logic    saida,
    output logic    ocupado,
    output logic    fim,
    output estado_t estado
);

    localparam contador_t CARGA_ALTO   = carga(LARGURA);
    localparam contador_t CARGA_ESPERA = carga(N_ESPERA);

    estado_t   estado_q;
    estado_t   estado_d;
    contador_t cont_q;
    contador_t cont_d;
    logic      fim_q;
    logic      fim_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= OCIOSO;
            cont_q   <= '0;
            fim_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            fim_q    <= fim_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        fim_d    = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                if (entrada) begin
                    estado_d = ALTO;
                    cont_d   = CARGA_ALTO;
                end
            end
            ALTO: begin
                // Retrigger wins over termination, even with the counter at 0.
                if (modo && entrada) begin
                    cont_d = CARGA_ALTO;
                end else if (cont_q != '0) begin
                    cont_d = cont_q - 1'b1;
                end else begin
                    fim_d = 1'b1;
                    if (N_ESPERA == 0) begin
                        estado_d = OCIOSO;
                        cont_d   = '0;
                    end else begin
                        estado_d = ESPERA;
                        cont_d   = CARGA_ESPERA;
                    end
                end
            end
            ESPERA: begin
                if (cont_q != '0) begin
                    cont_d = cont_q - 1'b1;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
                cont_d   = '0;
            end
        endcase
    end

    assign saida   = (estado_q == ALTO);
    assign ocupado = (estado_q != OCIOSO);
    assign fim     = fim_q;
    assign estado  = estado_q;

endmodule

// File: rtl/estendedor_pulso.sv
// Multi-channel pulse stretcher: N_CANAIS independent channels sharing
// clock, reset and retrigger mode; per-channel state exposed on estado.
module estendedor_pulso
    import estendedor_pulso_pkg::estado_t;
#(
    parameter int N_CANAIS = 2,
    parameter int LARGURA  = 4,
    parameter int ESPERA   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CANAIS-1:0] entrada,
    input  logic                modo,
    output logic [N_CANAIS-1:0] saida,
    output logic [N_CANAIS-1:0] ocupado,
    output logic [N_CANAIS-1:0] fim,
    output estado_t [N_CANAIS-1:0] estado
);

    for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
        estendedor_canal #(
            .LARGURA  (LARGURA),
            .N_ESPERA (ESPERA)
        ) u_canal (
            .clk     (clk),
            .rst     (rst),
            .entrada (entrada[i]),
            .modo    (modo),
            .saida   (saida[i]),
            .ocupado (ocupado[i]),
            .fim     (fim[i]),
            .estado  (estado[i])
        );
    end

endmodule
